// File: rtl/uart_tx_param.sv
// ---------------------------------------------------------------------------
// uart_tx_param
//
// Parametrised UART transmitter. It accepts one word per valid/ready
// handshake and sends it out LSB first as a frame:
//   start bit, data bits, optional parity bit, stop bit(s).
// Every bit lasts OVERSAMPLE clock cycles.
// Parity is chosen per word at run time. clk_enable_o lets an external clock
// gate stop the bit-rate logic while the transmitter is idle.
//
// Parameters
//   DATA_BITS   data bits per frame (5..9)
//   OVERSAMPLE  clock cycles per bit period (2..256)
//   STOP_BITS   number of stop bits (1 or 2)
//
// Optional feature macro: UART_TX_BREAK_EN
//   When this macro is defined, the design gains a send_break_i input and a
//   BREAK state. Holding send_break_i in IDLE drives the line low. When the
//   input is released, the block sends a full stop period and then DONE.
//
// Ports
//   clk_i          system clock, never gated
//   rst_ni         asynchronous active-low reset
//   tx_valid_i     word available on tx_data_i
//   tx_ready_o     block can accept a word (state == IDLE)
//   tx_data_i      word to send, LSB first
//   parity_mode_i  00 none, 01 even, 10 odd, 11 none
//   send_break_i   hold line low (only with UART_TX_BREAK_EN)
//   tx_o           serial line, idle high
//   busy_o         frame in progress
//   tx_done_o      one-cycle pulse at end of frame
//   state_o        FSM state, for debug
//   clk_enable_o   clock-gate enable for bit-rate logic
// ---------------------------------------------------------------------------
module uart_tx_param #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 tx_valid_i,
    output logic                 tx_ready_o,
    input  logic [DATA_BITS-1:0] tx_data_i,
    input  logic [1:0]           parity_mode_i,
`ifdef UART_TX_BREAK_EN
    input  logic                 send_break_i,
`endif
    output logic                 tx_o,
    output logic                 busy_o,
    output logic                 tx_done_o,
    output logic [2:0]           state_o,
    output logic                 clk_enable_o
);

    localparam int BAUD_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        DONE   = 3'd5
`ifdef UART_TX_BREAK_EN
        ,BREAK = 3'd6
`endif
    } state_t;

    state_t                 state_q;
    logic [BAUD_W-1:0]      baud_q;
    logic [BAUD_W-1:0]      baud_d;
    logic [BIT_W-1:0]       bit_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic                   parity_q;
    logic                   use_par_q;
    logic                   tx_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   ce_q;
    logic                   baud_last;

    // The baud counter wraps on its terminal count. In every bit state, the
    // wrap edge is the edge where the FSM moves to the next bit.
    assign baud_last = (baud_q == BAUD_W'(OVERSAMPLE - 1));
    assign baud_d    = baud_last ? '0 : baud_q + BAUD_W'(1);

    // Single FSM with registered outputs. tx, busy and state are updated on
    // the same edge, so the line never glitches between states. bit_q counts
    // data bits in DATA and is reused as the stop-bit counter in STOP.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            use_par_q <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ce_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    baud_q <= '0;
                    bit_q  <= '0;
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                    ce_q   <= 1'b0;
`ifdef UART_TX_BREAK_EN
                    // Break has priority over data; no word is accepted here.
                    if (send_break_i) begin
                        state_q <= BREAK;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        ce_q    <= 1'b1;
                    end else
`endif
                    if (tx_valid_i) begin
                        // Parity is fixed at accept time. Mode bit 1 selects
                        // odd parity. Either mode bit alone enables parity.
                        state_q   <= START;
                        shift_q   <= tx_data_i;
                        parity_q  <= (^tx_data_i) ^ parity_mode_i[1];
                        use_par_q <= parity_mode_i[0] ^ parity_mode_i[1];
                        tx_q      <= 1'b0;
                        busy_q    <= 1'b1;
                        ce_q      <= 1'b1;
                    end
                end
                START: begin
                    baud_q <= baud_d;
                    if (baud_last) begin
                        state_q <= DATA;
                        tx_q    <= shift_q[0];
                        shift_q <= shift_q >> 1;
                    end
                end
                DATA: begin
                    baud_q <= baud_d;
                    if (baud_last) begin
                        if (bit_q == BIT_W'(DATA_BITS - 1)) begin
                            bit_q <= '0;
                            if (use_par_q) begin
                                state_q <= PARITY;
                                tx_q    <= parity_q;
                            end else begin
                                state_q <= STOP;
                                tx_q    <= 1'b1;
                            end
                        end else begin
                            bit_q   <= bit_q + BIT_W'(1);
                            tx_q    <= shift_q[0];
                            shift_q <= shift_q >> 1;
                        end
                    end
                end
                PARITY: begin
                    baud_q <= baud_d;
                    if (baud_last) begin
                        state_q <= STOP;
                        tx_q    <= 1'b1;
                    end
                end
                STOP: begin
                    baud_q <= baud_d;
                    if (baud_last) begin
                        if (bit_q == BIT_W'(STOP_BITS - 1)) begin
                            state_q <= DONE;
                            bit_q   <= '0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            bit_q <= bit_q + BIT_W'(1);
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    ce_q    <= 1'b0;
                end
`ifdef UART_TX_BREAK_EN
                BREAK: begin
                    tx_q <= 1'b0;
                    if (!send_break_i) begin
                        state_q <= STOP;
                        tx_q    <= 1'b1;
                        baud_q  <= '0;
                        bit_q   <= '0;
                    end
                end
`endif
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    ce_q    <= 1'b0;
                    baud_q  <= '0;
                    bit_q   <= '0;
                end
            endcase
        end
    end

    assign tx_ready_o   = (state_q == IDLE);
    assign tx_o         = tx_q;
    assign busy_o       = busy_q;
    assign tx_done_o    = done_q;
    assign state_o      = state_q;
    assign clk_enable_o = ce_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_param
//
// Self-checking bench for uart_tx_param. It drives two instances:
//   dut 0: defaults (8 data bits, 16x oversample, 1 stop bit)
//   dut 1: 5 data bits, 4x oversample, 2 stop bits
// When a word is accepted, the bench pushes the expected line level for each
// bit of the frame onto a queue. It pops each level and compares it on every
// cycle of that bit.
// ---------------------------------------------------------------------------
module tb_uart_tx_param;

    logic       clk;
    logic       rst_n;
    logic       sbrk;
    logic       vld    [2];
    logic [8:0] dat    [2];
    logic [1:0] md     [2];
    logic       txO    [2];
    logic       busyO  [2];
    logic       readyO [2];
    logic       doneO  [2];
    logic       ceO    [2];
    logic [2:0] stO    [2];

    int   checks = 0;
    int   errors = 0;
    logic expQ [$];

    // Free-running system clock with a 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    uart_tx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .STOP_BITS(1)) dutA (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .tx_valid_i   (vld[0]),
        .tx_ready_o   (readyO[0]),
        .tx_data_i    (dat[0][7:0]),
        .parity_mode_i(md[0]),
`ifdef UART_TX_BREAK_EN
        .send_break_i (sbrk),
`endif
        .tx_o         (txO[0]),
        .busy_o       (busyO[0]),
        .tx_done_o    (doneO[0]),
        .state_o      (stO[0]),
        .clk_enable_o (ceO[0])
    );

    uart_tx_param #(.DATA_BITS(5), .OVERSAMPLE(4), .STOP_BITS(2)) dutB (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .tx_valid_i   (vld[1]),
        .tx_ready_o   (readyO[1]),
        .tx_data_i    (dat[1][4:0]),
        .parity_mode_i(md[1]),
`ifdef UART_TX_BREAK_EN
        .send_break_i (1'b0),
`endif
        .tx_o         (txO[1]),
        .busy_o       (busyO[1]),
        .tx_done_o    (doneO[1]),
        .state_o      (stO[1]),
        .clk_enable_o (ceO[1])
    );

    // Compares one observation with its expected value. On a mismatch it
    // counts the error and reports both values.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks the idle state one cycle after DONE.
    task automatic checkIdle(input int d);
        checkOutput("idleReady", readyO[d], 1);
        checkOutput("idleState", stO[d], 0);
        checkOutput("idleTx", txO[d], 1);
        checkOutput("idleBusy", busyO[d], 0);
        checkOutput("idleDone", doneO[d], 0);
        checkOutput("idleClkEn", ceO[d], 0);
    endtask

    // Sends one word, starting at a negedge. It returns at the negedge of the
    // DONE cycle. waits counts the negedges spent waiting for tx_ready.
    // When hold is set, tx_valid stays high and tx_data switches to nextData
    // after the accept edge, ready for back-to-back frames.
    task automatic applyStimulus(input int d, input logic [8:0] data, input logic [1:0] mode,
                                 input bit hold, input logic [8:0] nextData, output int waits);
        int   os;
        int   nb;
        int   ns;
        int   nbits;
        logic par;
        logic bitv;
        os    = (d == 0) ? 16 : 4;
        nb    = (d == 0) ? 8 : 5;
        ns    = (d == 0) ? 1 : 2;
        vld[d] = 1'b1;
        dat[d] = data;
        md[d]  = mode;
        waits  = 0;
        while (!readyO[d] && waits < 1000) begin
            @(negedge clk);
            waits++;
        end
        checkOutput("acceptReady", readyO[d], 1);
        expQ.push_back(1'b0);
        par = 1'b0;
        for (int i = 0; i < nb; i++) begin
            expQ.push_back(data[i]);
            par = par ^ data[i];
        end
        if (mode == 2'b01) expQ.push_back(par);
        else if (mode == 2'b10) expQ.push_back(~par);
        for (int i = 0; i < ns; i++) expQ.push_back(1'b1);
        @(posedge clk);
        nbits = expQ.size();
        for (int b = 0; b < nbits; b++) begin
            bitv = expQ.pop_front();
            for (int c = 0; c < os; c++) begin
                @(negedge clk);
                checkOutput("txBit", txO[d], bitv);
                checkOutput("frameBusy", busyO[d], 1);
                checkOutput("frameClkEn", ceO[d], 1);
                checkOutput("frameReady", readyO[d], 0);
                if (b == 0 && c == 0) begin
                    if (hold) begin
                        dat[d] = nextData;
                    end else begin
                        vld[d] = 1'b0;
                        dat[d] = ~data;
                        md[d]  = 2'b11;
                    end
                end
            end
        end
        @(negedge clk);
        checkOutput("doneState", stO[d], 5);
        checkOutput("donePulse", doneO[d], 1);
        checkOutput("doneBusy", busyO[d], 0);
        checkOutput("doneTx", txO[d], 1);
        checkOutput("doneClkEn", ceO[d], 1);
    endtask

    // Watchdog: stops the run if the sequence stalls.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence: reset, default frames with every parity mode,
    // back-to-back accept, the small configuration, reset mid-frame, and break.
    initial begin
        int w;
        rst_n = 1'b0;
        sbrk  = 1'b0;
        for (int d = 0; d < 2; d++) begin
            vld[d] = 1'b0;
            dat[d] = '0;
            md[d]  = 2'b00;
        end
        repeat (3) @(negedge clk);
        checkIdle(0);
        checkIdle(1);
        rst_n = 1'b1;
        @(negedge clk);

        applyStimulus(0, 9'h0A5, 2'b00, 1'b0, 9'h000, w);
        @(negedge clk);
        checkIdle(0);

        applyStimulus(0, 9'h0A5, 2'b01, 1'b0, 9'h000, w);
        @(negedge clk);
        checkIdle(0);
        applyStimulus(0, 9'h0A5, 2'b10, 1'b0, 9'h000, w);
        @(negedge clk);
        checkIdle(0);

        applyStimulus(0, 9'h001, 2'b00, 1'b1, 9'h002, w);
        applyStimulus(0, 9'h002, 2'b00, 1'b0, 9'h000, w);
        checkOutput("gapWaits", w, 1);
        @(negedge clk);
        checkIdle(0);

        applyStimulus(1, 9'h013, 2'b00, 1'b0, 9'h000, w);
        @(negedge clk);
        checkIdle(1);
        applyStimulus(1, 9'h00B, 2'b10, 1'b0, 9'h000, w);
        @(negedge clk);
        checkIdle(1);

        vld[0] = 1'b1;
        dat[0] = 9'h05A;
        md[0]  = 2'b00;
        @(posedge clk);
        @(negedge clk);
        vld[0] = 1'b0;
        repeat (69) @(negedge clk);
        checkOutput("midState", stO[0], 2);
        rst_n = 1'b0;
        #1;
        checkOutput("rstTx", txO[0], 1);
        checkOutput("rstBusy", busyO[0], 0);
        checkOutput("rstState", stO[0], 0);
        checkOutput("rstClkEn", ceO[0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(0, 9'h03C, 2'b10, 1'b0, 9'h000, w);
        @(negedge clk);
        checkIdle(0);

`ifdef UART_TX_BREAK_EN
        sbrk   = 1'b1;
        vld[0] = 1'b1;
        dat[0] = 9'h055;
        @(posedge clk);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            checkOutput("brkTx", txO[0], 0);
            checkOutput("brkState", stO[0], 6);
            checkOutput("brkReady", readyO[0], 0);
            checkOutput("brkBusy", busyO[0], 1);
            checkOutput("brkClkEn", ceO[0], 1);
            if (i == 49) sbrk = 1'b0;
        end
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            checkOutput("brkStopTx", txO[0], 1);
            checkOutput("brkStopState", stO[0], 4);
            checkOutput("brkStopBusy", busyO[0], 1);
        end
        @(negedge clk);
        checkOutput("brkDoneState", stO[0], 5);
        checkOutput("brkDonePulse", doneO[0], 1);
        vld[0] = 1'b0;
        @(negedge clk);
        checkIdle(0);
`endif

        checkOutput("queueEmpty", expQ.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
